mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage data-memory access unit. It sits between the MEM stage register and StageRegWB.
//  It turns the stage's load/store request into a handshaked data-memory transaction.
//  It supports byte, halfword and word sizes, with lane steering and sign/zero extension.
//  It stalls the pipeline until the memory responds, and produces memMemOut for the WB stage register.
// PARAMETERS
//  WAIT_LIMIT  0  max cycles in REQ before abort with memBusErr; 0 = no limit
// PORTS
//  clk             in   1   single clock; FSM and output registers update on posedge
//  rst             in   1   asynchronous, active-high reset
//  memMemRead      in   1   MEM-stage instruction is a load
//  memMemWrite     in   1   MEM-stage instruction is a store
//  memSize         in   2   00 byte, 01 half, 10 word, 11 treated as word
//  memSigned       in   1   load result sign-extended (1) or zero-extended (0)
//  memAluOut       in   32  effective byte address
//  memWriteData    in   32  store data (rt), right-aligned
//  memMemOut       out  32  load result for StageRegWB
//  memStall        out  1   hold IF..MEM stage registers; combinational
//  memAddrErr      out  1   misaligned access; combinational
//  memBusErr       out  1   access aborted by WAIT_LIMIT; 1-cycle pulse in DONE
//  dmemReq         out  1   memory request; registered
//  dmemWe          out  1   request is a write
//  dmemAddr        out  30  word address = memAluOut[31:2]
//  dmemBe          out  4   byte enables, bit i = byte lane i (little-endian)
//  dmemWdata       out  32  lane-steered store data
//  dmemRdata       in   32  read data; valid when dmemReady=1
//  dmemReady       in   1   completes the transaction at the posedge it is sampled high in REQ
// BEHAVIOUR
//  - access   = (memMemRead | memMemWrite) & ~memAddrErr.
//  - memAddrErr = half with addr[0]=1, or word with addr[1:0]!=0. A misaligned op issues no request and never stalls.
//  - States are IDLE, REQ and DONE. The reset state is IDLE.
//  - IDLE -> REQ when access is asserted.
//  - REQ  -> DONE when dmemReady is 1, or when the REQ cycle count reaches WAIT_LIMIT (WAIT_LIMIT != 0).
//  - DONE -> REQ if access is asserted (a new instruction has been latched at the negedge); otherwise DONE -> IDLE.
//  - memStall = access & (state != DONE). The stage registers advance at the negedge that falls inside DONE.
//  - dmemReq = (state == REQ).
//  - dmemWe, dmemAddr, dmemBe and dmemWdata are registered on entry to REQ and held stable while in REQ.
//  - Outside REQ, dmemWe, dmemBe and dmemWdata are 0, and dmemReady is ignored.
//  - Store byte enables:
//      byte: dmemBe = 4'b0001 << addr[1:0]; dmemWdata = {4{wd[7:0]}}
//      half: dmemBe = addr[1] ? 4'b1100 : 4'b0011; dmemWdata = {2{wd[15:0]}}
//      word: dmemBe = 4'b1111; dmemWdata = wd
//  - Loads request with dmemBe = 4'b1111. The selected lane is extended per memSigned and captured into memMemOut on the REQ->DONE edge.
//  - memMemOut holds its value until the next completed load. Stores, aborts and non-memory instructions leave it unchanged.
//  - On abort (WAIT_LIMIT reached): nothing is captured. memBusErr = 1 for the DONE cycle. The pipeline is released.
//  - Wait counter: 16 bits, cleared on entry to REQ, saturating.
//  - Reset (asynchronous, any time, including mid-REQ) forces:
//      state = IDLE; counter = 0
//      memMemOut = 0; dmemReq = dmemWe = 0; dmemBe = 0; dmemWdata = 0; dmemAddr = 0
//      memBusErr = 0
//  - After reset, a transaction the memory was in the middle of is abandoned; the unit does not wait for it.
// TESTING
//  - lw 0x100, memory returns 0x8899AABB with 0 waits:
//      memStall high 1 cycle, dmemBe=1111, dmemAddr=0x40; memMemOut=0x8899AABB in DONE.
//  - lb / lbu at 0x103, word 0x80112233:
//      lb -> 0xFFFFFF80; lbu -> 0x00000080.
//  - lh at 0x102, word 0x8001_7FFF:
//      -> 0xFFFF8001. lh at 0x101 -> memAddrErr=1, no dmemReq, memStall=0.
//  - sb 0x0000005A at 0x101:
//      dmemBe=0010, dmemWdata=0x5A5A5A5A, dmemWe=1. memMemOut is unchanged.
//  - Back-to-back lw then sw, 3 wait states each:
//      memStall high 4 cycles per access; DONE->REQ with no IDLE bubble; dmemAddr stable throughout REQ.
//  - WAIT_LIMIT=4, dmemReady never asserted:
//      abort after 4 REQ cycles, memBusErr 1-cycle pulse, memMemOut unchanged.
//  - rst asserted mid-REQ:
//      dmemReq=0 immediately, state IDLE; a new access after release runs normally.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : MEM-stage data-memory access unit. Turns the stage's
//                load/store request into a handshaked memory transaction,
//                steers byte lanes, extends load data and stalls the
//                pipeline until the memory responds or the wait limit hits.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memMemRead,
  input  logic        memMemWrite,
  input  logic [1:0]  memSize,
  input  logic        memSigned,
  input  logic [31:0] memAluOut,
  input  logic [31:0] memWriteData,
  output logic [31:0] memMemOut,
  output logic        memStall,
  output logic        memAddrErr,
  output logic        memBusErr,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [29:0] dmemAddr,
  output logic [3:0]  dmemBe,
  output logic [31:0] dmemWdata,
  input  logic [31:0] dmemRdata,
  input  logic        dmemReady
);

  // A zero limit disables the abort path entirely.
  localparam logic        HAS_LIMIT = (WAIT_LIMIT != 0);
  // The abort fires during the WAIT_LIMIT-th REQ cycle, i.e. when the
  // counter (cleared on entry) has counted WAIT_LIMIT-1 completed cycles.
  localparam logic [31:0] LIMIT_M1  = HAS_LIMIT ? 32'(WAIT_LIMIT - 1) : 32'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic         is_byte;
  logic         is_half;
  logic         mem_op;
  logic         misalign;
  logic         access;
  logic         enter_req;
  logic         leave_req;
  logic         timeout;
  logic [15:0]  wait_cnt;

  logic [3:0]   be_nxt;
  logic [31:0]  wdata_nxt;

  // Load attributes latched with the request so the capture does not depend
  // on the stage inputs staying put.
  logic         ld_is_load;
  logic [1:0]   ld_size;
  logic         ld_signed;
  logic [1:0]   ld_off;

  logic [7:0]   lane_byte;
  logic [15:0]  lane_half;
  logic [31:0]  load_val;

  assign is_byte = (memSize == 2'b00);
  assign is_half = (memSize == 2'b01);
  assign mem_op  = memMemRead | memMemWrite;

  // Alignment check: halves need addr[0]=0, words (and size 11) need addr[1:0]=0.
  always_comb begin
    misalign = 1'b0;
    if (is_half) begin
      misalign = memAluOut[0];
    end else if (!is_byte) begin
      misalign = (memAluOut[1:0] != 2'b00);
    end
  end

  assign memAddrErr = mem_op & misalign;
  assign access     = mem_op & ~misalign;

  assign timeout = HAS_LIMIT && ({16'd0, wait_cnt} >= LIMIT_M1);

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; a ready response wins over a timeout.
  always_comb begin
    state_nxt = state;
    memStall  = 1'b0;
    dmemReq   = 1'b0;
    case (state)
      IDLE: begin
        if (access) state_nxt = REQ;
      end
      REQ: begin
        dmemReq = 1'b1;
        if (dmemReady || timeout) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = access ? REQ : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    memStall = access & (state != DONE);
  end

  assign enter_req = (state != REQ) && (state_nxt == REQ);
  assign leave_req = (state == REQ) && (state_nxt == DONE);

  // Store lane steering; loads always fetch the full word.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = 32'd0;
    if (memMemWrite) begin
      if (is_byte) begin
        be_nxt    = 4'b0001 << memAluOut[1:0];
        wdata_nxt = {4{memWriteData[7:0]}};
      end else if (is_half) begin
        be_nxt    = memAluOut[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{memWriteData[15:0]}};
      end else begin
        be_nxt    = 4'b1111;
        wdata_nxt = memWriteData;
      end
    end
  end

  // Request registers: loaded on entry to REQ, held through REQ, zeroed on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmemWe     <= 1'b0;
      dmemAddr   <= 30'd0;
      dmemBe     <= 4'd0;
      dmemWdata  <= 32'd0;
      ld_is_load <= 1'b0;
      ld_size    <= 2'b00;
      ld_signed  <= 1'b0;
      ld_off     <= 2'b00;
    end else if (enter_req) begin
      dmemWe     <= memMemWrite;
      dmemAddr   <= memAluOut[31:2];
      dmemBe     <= be_nxt;
      dmemWdata  <= wdata_nxt;
      ld_is_load <= memMemRead & ~memMemWrite;
      ld_size    <= memSize;
      ld_signed  <= memSigned;
      ld_off     <= memAluOut[1:0];
    end else if (leave_req) begin
      dmemWe     <= 1'b0;
      dmemBe     <= 4'd0;
      dmemWdata  <= 32'd0;
    end
  end

  // Wait counter: cleared on entry to REQ, counts REQ cycles, saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 16'd0;
    end else if (enter_req) begin
      wait_cnt <= 16'd0;
    end else if ((state == REQ) && (wait_cnt != 16'hFFFF)) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Pick the addressed lane from the returned word and extend it.
  always_comb begin
    lane_byte = 8'd0;
    case (ld_off)
      2'd0:    lane_byte = dmemRdata[7:0];
      2'd1:    lane_byte = dmemRdata[15:8];
      2'd2:    lane_byte = dmemRdata[23:16];
      default: lane_byte = dmemRdata[31:24];
    endcase
    lane_half = ld_off[1] ? dmemRdata[31:16] : dmemRdata[15:0];
    if (ld_size == 2'b00) begin
      load_val = {{24{ld_signed & lane_byte[7]}}, lane_byte};
    end else if (ld_size == 2'b01) begin
      load_val = {{16{ld_signed & lane_half[15]}}, lane_half};
    end else begin
      load_val = dmemRdata;
    end
  end

  // Load result only changes when a load completes with a ready response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memMemOut <= 32'd0;
    end else if ((state == REQ) && dmemReady && ld_is_load) begin
      memMemOut <= load_val;
    end
  end

  // Bus-error pulse covers exactly the DONE cycle following an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memBusErr <= 1'b0;
    end else begin
      memBusErr <= (state == REQ) && !dmemReady && timeout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit: directed vector
//                table, abort and reset corner sequences, randomized ops
//                against a byte-level memory reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int WL    = 4;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        rst;
  logic        memMemRead, memMemWrite, memSigned;
  logic [1:0]  memSize;
  logic [31:0] memAluOut, memWriteData;
  logic [31:0] memMemOut;
  logic        memStall, memAddrErr, memBusErr;
  logic        dmemReq, dmemWe;
  logic [29:0] dmemAddr;
  logic [3:0]  dmemBe;
  logic [31:0] dmemWdata, dmemRdata;
  logic        dmemReady;

  mem_access_unit #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst(rst),
    .memMemRead(memMemRead), .memMemWrite(memMemWrite),
    .memSize(memSize), .memSigned(memSigned),
    .memAluOut(memAluOut), .memWriteData(memWriteData),
    .memMemOut(memMemOut), .memStall(memStall),
    .memAddrErr(memAddrErr), .memBusErr(memBusErr),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr),
    .dmemBe(dmemBe), .dmemWdata(dmemWdata),
    .dmemRdata(dmemRdata), .dmemReady(dmemReady)
  );

  always #5 clk = ~clk;

  logic [31:0] dmem [0:255];   // contents as actually written by the DUT
  logic [31:0] refm [0:255];   // contents predicted by the model
  logic [31:0] exp_out;
  int npass = 0;
  int ntotal = 0;

  typedef struct {
    bit          rd, wr, sg, pre_en;
    logic [1:0]  sz;
    logic [31:0] addr, wd, pre;
    int          waits;
    logic [31:0] exp_out;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input int nb, input bit sg, input int off);
    longint v, span;
    span = longint'(1) << (8 * nb);
    v = (longint'(w) >> (8 * off)) & (span - 1);
    if (sg && nb < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // Drives one instruction right after a negedge and follows it to completion.
  task automatic do_op(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] addr, input logic [31:0] wd, input int waits,
                       input string tag, output logic [3:0] seen_be, output logic [31:0] seen_wd);
    int nb, off, reqs, stalls, exp_cyc, idx;
    bit misal, acc, aborted, done;
    logic [31:0] w, e_wd;
    logic [3:0]  e_be;
    nb      = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off     = int'(addr[1:0]);
    idx     = int'(addr[9:2]);
    misal   = (rd || wr) && (off % nb != 0);
    acc     = (rd || wr) && !misal;
    aborted = acc && (waits >= WL);
    exp_cyc = !acc ? 0 : (aborted ? WL : waits + 1);
    e_be    = wr ? 4'(((1 << nb) - 1) << off) : 4'hF;
    e_wd    = 32'd0;
    if (wr) for (int j = 0; j < 4; j++) e_wd[8*j +: 8] = wd[8*(j % nb) +: 8];
    seen_be = 4'd0;
    seen_wd = 32'd0;
    memMemRead = rd; memMemWrite = wr; memSize = sz; memSigned = sg;
    memAluOut = addr; memWriteData = wd;
    reqs = 0; stalls = 0; done = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        if (rd || wr) check({tag, " addrerr"}, {31'd0, memAddrErr}, {31'd0, misal});
        check({tag, " req_first"}, {31'd0, dmemReq}, {31'd0, acc});
        check({tag, " buserr_first"}, {31'd0, memBusErr}, 32'd0);
      end
      if (!memStall) begin
        done = 1;
        dmemReady = 1'($urandom_range(0, 1));
      end else if (!dmemReq) begin
        check({tag, " stall_without_req"}, {31'd0, dmemReq}, 32'd1);
        dmemReady = 1'b0;
      end else begin
        stalls++;
        reqs++;
        if (reqs == 1) begin seen_be = dmemBe; seen_wd = dmemWdata; end
        check({tag, " addr"}, {2'b00, dmemAddr}, {2'b00, addr[31:2]});
        check({tag, " we"}, {31'd0, dmemWe}, {31'd0, wr});
        check({tag, " be"}, {28'd0, dmemBe}, {28'd0, e_be});
        check({tag, " wdata"}, dmemWdata, e_wd);
        if (reqs > waits) begin
          dmemReady = 1'b1;
          if (dmemWe)
            for (int j = 0; j < 4; j++)
              if (dmemBe[j]) dmem[dmemAddr[7:0]][8*j +: 8] = dmemWdata[8*j +: 8];
          dmemRdata = dmem[dmemAddr[7:0]];
        end else begin
          dmemReady = 1'b0;
          dmemRdata = $urandom;
        end
      end
    end
    if (!done) check({tag, " completion_bound"}, {31'd0, memStall}, 32'd0);
    if (acc && !aborted) begin
      w = refm[idx];
      if (wr) begin
        for (int i = 0; i < nb; i++) w[8*(off + i) +: 8] = wd[8*i +: 8];
        refm[idx] = w;
      end else begin
        exp_out = model_load(w, nb, sg, off);
      end
    end
    check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_cyc));
    check({tag, " buserr"}, {31'd0, memBusErr}, {31'd0, aborted});
    check({tag, " memout"}, memMemOut, exp_out);
    check({tag, " idle_bus"}, {27'd0, dmemReq, dmemWe, dmemBe}, 32'd0);
    check({tag, " idle_wdata"}, dmemWdata, 32'd0);
  endtask

  initial begin
    vec_t vt[$];
    logic [3:0]  sbe;
    logic [31:0] swd;
    int idx;

    for (int i = 0; i < 256; i++) begin dmem[i] = $urandom; refm[i] = dmem[i]; end
    exp_out = 32'd0;
    rst = 1'b1; memMemRead = 0; memMemWrite = 0; memSize = 0; memSigned = 0;
    memAluOut = 0; memWriteData = 0; dmemRdata = 0; dmemReady = 0;
    repeat (2) @(negedge clk);
    check("reset memout", memMemOut, 32'd0);
    check("reset ctl", {26'd0, dmemReq, dmemWe, memStall, memBusErr, memAddrErr, 1'b0}, 32'd0);
    check("reset be", {28'd0, dmemBe}, 32'd0);
    check("reset wdata", dmemWdata, 32'd0);
    check("reset addr", {2'b00, dmemAddr}, 32'd0);
    rst = 1'b0;

    //          rd wr sg pre sz     addr          wd            pre           waits exp_out       be       wd
    vt.push_back('{1, 0, 0, 1, 2'b10, 32'h100, 32'h0,        32'h8899AABB, 0, 32'h8899AABB, 4'hF, 32'h0});
    vt.push_back('{1, 0, 1, 1, 2'b00, 32'h103, 32'h0,        32'h80112233, 0, 32'hFFFFFF80, 4'hF, 32'h0});
    vt.push_back('{1, 0, 0, 1, 2'b00, 32'h103, 32'h0,        32'h80112233, 1, 32'h00000080, 4'hF, 32'h0});
    vt.push_back('{1, 0, 1, 1, 2'b01, 32'h102, 32'h0,        32'h80017FFF, 0, 32'hFFFF8001, 4'hF, 32'h0});
    vt.push_back('{1, 0, 1, 0, 2'b01, 32'h101, 32'h0,        32'h0,        0, 32'hFFFF8001, 4'h0, 32'h0});
    vt.push_back('{0, 1, 0, 1, 2'b00, 32'h101, 32'h0000005A, 32'h0,        0, 32'hFFFF8001, 4'h2, 32'h5A5A5A5A});
    vt.push_back('{1, 0, 0, 1, 2'b10, 32'h100, 32'h0,        32'h11223344, 3, 32'h11223344, 4'hF, 32'h0});
    vt.push_back('{0, 1, 0, 0, 2'b10, 32'h104, 32'hDEADBEEF, 32'h0,        3, 32'h11223344, 4'hF, 32'hDEADBEEF});
    vt.push_back('{1, 0, 0, 0, 2'b01, 32'h106, 32'h0,        32'h0,        2, 32'h0000DEAD, 4'hF, 32'h0});
    vt.push_back('{0, 1, 0, 0, 2'b01, 32'h10A, 32'hABCD1234, 32'h0,        1, 32'h0000DEAD, 4'hC, 32'h12341234});
    vt.push_back('{1, 0, 1, 0, 2'b00, 32'h10B, 32'h0,        32'h0,        0, 32'h00000012, 4'hF, 32'h0});
    vt.push_back('{1, 0, 0, 0, 2'b11, 32'h104, 32'h0,        32'h0,        0, 32'hDEADBEEF, 4'hF, 32'h0});

    foreach (vt[k]) begin
      if (vt[k].pre_en) begin
        idx = int'(vt[k].addr[9:2]);
        dmem[idx] = vt[k].pre;
        refm[idx] = vt[k].pre;
      end
      do_op(vt[k].rd, vt[k].wr, vt[k].sz, vt[k].sg, vt[k].addr, vt[k].wd, vt[k].waits,
            $sformatf("vec%0d", k), sbe, swd);
      check($sformatf("vec%0d table_out", k), memMemOut, vt[k].exp_out);
      check($sformatf("vec%0d table_be", k), {28'd0, sbe}, {28'd0, vt[k].exp_be});
      check($sformatf("vec%0d table_wd", k), swd, vt[k].exp_wd);
    end

    // Abort: load and store that never get ready, then a nop to see the pulse end.
    do_op(1, 0, 2'b10, 0, 32'h200, 32'h0, NEVER, "abort_lw", sbe, swd);
    do_op(0, 0, 2'b00, 0, 32'h0, 32'h0, 0, "after_abort", sbe, swd);
    check("after_abort pulse_gone", {31'd0, memBusErr}, 32'd0);
    do_op(0, 1, 2'b10, 0, 32'h204, 32'hCAFEF00D, NEVER, "abort_sw", sbe, swd);
    do_op(1, 0, 2'b10, 0, 32'h204, 32'h0, 0, "read_after_abort_sw", sbe, swd);

    // Reset in the middle of a request.
    memMemRead = 1; memMemWrite = 0; memSize = 2'b10; memAluOut = 32'h140; dmemReady = 0;
    repeat (3) @(negedge clk);
    check("midreq req_before_rst", {31'd0, dmemReq}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midreq req_after_rst", {31'd0, dmemReq}, 32'd0);
    check("midreq bus_after_rst", {27'd0, dmemWe, dmemBe}, 32'd0);
    check("midreq addr_after_rst", {2'b00, dmemAddr}, 32'd0);
    check("midreq memout_after_rst", memMemOut, 32'd0);
    exp_out = 32'd0;
    memMemRead = 0;
    @(negedge clk);
    rst = 1'b0;
    do_op(1, 0, 2'b10, 0, 32'h140, 32'h0, 1, "after_rst_lw", sbe, swd);

    // Randomized mix of loads, stores, nops, misalignment and aborts.
    for (int n = 0; n < 150; n++) begin
      int kind, wt;
      kind = $urandom_range(0, 5);
      wt   = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 3);
      do_op(kind >= 1 && kind <= 3, kind >= 4, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 1023)), $urandom, wt, $sformatf("rnd%0d", n), sbe, swd);
    end

    // Final sweep: every word the DUT wrote must match the model.
    for (int i = 0; i < 256; i++)
      if (dmem[i] !== refm[i]) check($sformatf("mem word %0d", i), dmem[i], refm[i]);
    check("mem sweep sample", dmem[8'h41], refm[8'h41]);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
`default_nettype wire
